dmem_responder: RTL and testbench

Data-memory responder for the single-cycle RV32I core: the slave end of the core's dmem interface. It decodes each access into a word-addressed RAM region or an MMIO page that holds a console TX FIFO, a 64-bit cycle counter and a tohost register. Reads are combinational so the core completes loads in the same cycle; all state changes happen on the rising clock edge. It sits beside the instruction memory in the simulation/FPGA top and is the bench's main observation point for program output and pass/fail.

---
 rtl/dmem_responder.sv | 203 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus an MMIO page (console TX FIFO, cycle counter, tohost).
// The 64-bit cycle counter and its hi shadow exist only when DMEM_RESP_CYCLE_COUNTER_EN is defined.
module dmem_responder #(
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter int unsigned           MEM_DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE       = 32'h1000_0000,
  parameter int unsigned           FIFO_DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   dmem_addr,
  input  logic [DATA_WIDTH-1:0]   dmem_wdata,
  input  logic                    dmem_write,
  input  logic [DATA_WIDTH/8-1:0] dmem_wstrb,
  input  logic                    dmem_read,
  output logic [DATA_WIDTH-1:0]   dmem_rdata,
  output logic                    console_valid,
  output logic [7:0]              console_data,
  input  logic                    console_ready,
  output logic                    tohost_valid,
  output logic [DATA_WIDTH-1:0]   tohost_data,
  output logic                    fault,
  output logic [ADDR_WIDTH-1:0]   fault_addr
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = $clog2(MEM_DEPTH_WORDS);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [9:0] OFF_TX     = 10'h000;
  localparam logic [9:0] OFF_STATUS = 10'h001;
  localparam logic [9:0] OFF_LO     = 10'h002;
  localparam logic [9:0] OFF_HI     = 10'h003;
  localparam logic [9:0] OFF_TOHOST = 10'h004;

  logic             ram_hit, mmio_hit, unmapped;
  logic [IDX_W-1:0] word_idx;
  logic [9:0]       mmio_off;
  logic [1:0]       unused_byte_off;

  assign ram_hit         = (dmem_addr[ADDR_WIDTH-1:IDX_W+2] == '0);
  assign mmio_hit        = (dmem_addr[ADDR_WIDTH-1:12] == MMIO_BASE[ADDR_WIDTH-1:12]);
  assign unmapped        = (dmem_read || dmem_write) && !ram_hit && !mmio_hit;
  assign word_idx        = dmem_addr[IDX_W+1:2];
  assign mmio_off        = dmem_addr[11:2];
  assign unused_byte_off = dmem_addr[1:0];

  // RAM split into one byte-wide array per lane so each strobe owns its own storage.
  logic [DATA_WIDTH-1:0] ram_rdata;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] lane_mem [MEM_DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (dmem_write && ram_hit && dmem_wstrb[gi]) begin
          lane_mem[word_idx] <= dmem_wdata[8*gi +: 8];
        end
      end

      assign ram_rdata[8*gi +: 8] = lane_mem[word_idx];
    end
  endgenerate

  // Console TX FIFO
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic [15:0]      drop_q, drop_d;
  logic             fifo_full, fifo_empty, push_req, push_acc, pop;

  assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign pop        = !fifo_empty && console_ready;
  assign push_req   = dmem_write && mmio_hit && (mmio_off == OFF_TX) && dmem_wstrb[0];
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_acc   = push_req && (!fifo_full || pop);

  always_comb begin
    level_d = level_q;
    if (push_acc && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (!push_acc && pop) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (push_req && !push_acc && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      fifo_mem[wr_ptr_q] <= dmem_wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)      rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
      drop_q  <= drop_d;
    end
  end

  assign console_valid = !fifo_empty;
  assign console_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];

  logic [31:0] status_word;
  always_comb begin
    status_word        = '0;
    status_word[0]     = fifo_full;
    status_word[1]     = fifo_empty;
    status_word[7:4]   = 4'(level_q);
    status_word[31:16] = drop_q;
  end

  logic [31:0] cycle_lo_rd, cycle_hi_rd;

`ifdef DMEM_RESP_CYCLE_COUNTER_EN
  logic [63:0] cycle_q;
  logic [31:0] cycle_hi_q;
  logic        lo_rd;

  assign lo_rd = dmem_read && mmio_hit && (mmio_off == OFF_LO);

  // Reading LO snapshots the upper half so a following HI read is coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q    <= '0;
      cycle_hi_q <= '0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (lo_rd) cycle_hi_q <= cycle_q[63:32];
    end
  end

  assign cycle_lo_rd = cycle_q[31:0];
  assign cycle_hi_rd = cycle_hi_q;
`else
  assign cycle_lo_rd = '0;
  assign cycle_hi_rd = '0;
`endif

  logic                  tohost_valid_q, fault_q;
  logic [DATA_WIDTH-1:0] tohost_data_q;
  logic [ADDR_WIDTH-1:0] fault_addr_q;
  logic                  tohost_wr;

  assign tohost_wr = dmem_write && mmio_hit && (mmio_off == OFF_TOHOST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tohost_valid_q <= 1'b0;
      tohost_data_q  <= '0;
      fault_q        <= 1'b0;
      fault_addr_q   <= '0;
    end else begin
      if (tohost_wr) begin
        tohost_valid_q <= 1'b1;
        tohost_data_q  <= dmem_wdata;
      end
      if (unmapped) begin
        fault_q <= 1'b1;
        if (!fault_q) fault_addr_q <= dmem_addr;
      end
    end
  end

  assign tohost_valid = tohost_valid_q;
  assign tohost_data  = tohost_data_q;
  assign fault        = fault_q;
  assign fault_addr   = fault_addr_q;

  always_comb begin
    dmem_rdata = '0;
    if (dmem_read) begin
      if (ram_hit) begin
        dmem_rdata = ram_rdata;
      end else if (mmio_hit) begin
        case (mmio_off)
          OFF_STATUS: dmem_rdata = status_word;
          OFF_LO:     dmem_rdata = cycle_lo_rd;
          OFF_HI:     dmem_rdata = cycle_hi_rd;
          OFF_TOHOST: dmem_rdata = tohost_data_q;
          default:    dmem_rdata = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM strobes, console FIFO, cycle counter, tohost, fault and reset.
module tb_dmem_responder;

  localparam logic [31:0] MB = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_write;
  logic [3:0]  dmem_wstrb;
  logic        dmem_read;
  logic [31:0] dmem_rdata;
  logic        console_valid;
  logic [7:0]  console_data;
  logic        console_ready;
  logic        tohost_valid;
  logic [31:0] tohost_data;
  logic        fault;
  logic [31:0] fault_addr;

  int checks = 0;
  int errors = 0;
  logic [31:0] rv;

  dmem_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_write    (dmem_write),
    .dmem_wstrb    (dmem_wstrb),
    .dmem_read     (dmem_read),
    .dmem_rdata    (dmem_rdata),
    .console_valid (console_valid),
    .console_data  (console_data),
    .console_ready (console_ready),
    .tohost_valid  (tohost_valid),
    .tohost_data   (tohost_data),
    .fault         (fault),
    .fault_addr    (fault_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    dmem_addr  = a;
    dmem_wdata = d;
    dmem_wstrb = s;
    dmem_write = 1'b1;
    tick();
    dmem_write = 1'b0;
    dmem_wstrb = 4'b0000;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    dmem_addr = a;
    dmem_read = 1'b1;
    #1;
    d = dmem_rdata;
    tick();
    dmem_read = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    dmem_addr     = '0;
    dmem_wdata    = '0;
    dmem_write    = 1'b0;
    dmem_wstrb    = '0;
    dmem_read     = 1'b0;
    console_ready = 1'b0;
    repeat (3) tick();

    chk("rst_console_valid", console_valid, 0);
    chk("rst_console_data", console_data, 0);
    chk("rst_tohost_valid", tohost_valid, 0);
    chk("rst_tohost_data", tohost_data, 0);
    chk("rst_fault", fault, 0);
    chk("rst_fault_addr", fault_addr, 0);
    chk("rst_rdata_idle", dmem_rdata, 0);

    rst_n = 1'b1;
    repeat (5) tick();

`ifdef DMEM_RESP_CYCLE_COUNTER_EN
    rd(MB + 32'h8, rv);  chk("cycle_lo_5", rv, 32'h5);
    rd(MB + 32'hC, rv);  chk("cycle_hi_0", rv, 32'h0);
    force dut.cycle_q = 64'h0000_0002_FFFF_FFFE;
    #1;
    release dut.cycle_q;
    rd(MB + 32'h8, rv);  chk("cycle_lo_near_wrap", rv, 32'hFFFF_FFFE);
    tick();
    tick();
    rd(MB + 32'hC, rv);  chk("cycle_hi_latched", rv, 32'h2);
    rd(MB + 32'h8, rv);  chk("cycle_lo_wrapped", rv, 32'h2);
`else
    rd(MB + 32'h8, rv);  chk("cycle_lo_off", rv, 32'h0);
    rd(MB + 32'hC, rv);  chk("cycle_hi_off", rv, 32'h0);
`endif
    chk("cycle_no_fault", fault, 0);

    // RAM byte strobes
    wr(32'h40, 32'hDEAD_BEEF, 4'b1111);
    wr(32'h40, 32'h0000_00AA, 4'b0001);
    rd(32'h40, rv);  chk("ram_strb_lane0", rv, 32'hDEAD_BEAA);
    rd(32'h42, rv);  chk("ram_unaligned", rv, 32'hDEAD_BEAA);
    wr(32'h44, 32'h0000_0000, 4'b1111);
    wr(32'h44, 32'h1122_3344, 4'b0100);
    rd(32'h44, rv);  chk("ram_strb_lane2", rv, 32'h0022_0000);
    wr(32'hFFC, 32'hCAFE_F00D, 4'b1111);
    rd(32'hFFC, rv); chk("ram_top_word", rv, 32'hCAFE_F00D);

    // Read and write in the same cycle: read sees pre-edge contents
    dmem_addr  = 32'h40;
    dmem_wdata = 32'h1234_5678;
    dmem_wstrb = 4'b1111;
    dmem_write = 1'b1;
    dmem_read  = 1'b1;
    #1;
    chk("rw_pre_edge", dmem_rdata, 32'hDEAD_BEAA);
    tick();
    dmem_write = 1'b0;
    dmem_read  = 1'b0;
    dmem_wstrb = 4'b0000;
    rd(32'h40, rv);  chk("rw_post_edge", rv, 32'h1234_5678);

    // Console fill with ready low
    rd(MB + 32'h4, rv); chk("status_empty", rv, 32'h0000_0002);
    wr(MB, 32'h41, 4'b0001);
    chk("push1_valid", console_valid, 1);
    chk("push1_data", console_data, 8'h41);
    for (int i = 1; i < 10; i++) wr(MB, 32'h41 + i, 4'b0001);
    rd(MB + 32'h4, rv); chk("status_full_drop2", rv, 32'h0002_0081);
    chk("head_held", console_data, 8'h41);
    wr(MB + 32'h4, 32'hFFFF_FFFF, 4'b1111);
    rd(MB + 32'h4, rv); chk("status_write_ignored", rv, 32'h0002_0081);

    console_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain1_valid_%0d", i), console_valid, 1);
      chk($sformatf("drain1_data_%0d", i), console_data, 8'h41 + i);
      tick();
    end
    chk("drain1_done", console_valid, 0);
    console_ready = 1'b0;
    rd(MB + 32'h4, rv); chk("status_drained", rv, 32'h0002_0002);

    // Full FIFO with push and pop on the same edge
    for (int i = 0; i < 8; i++) wr(MB, 32'h50 + i, 4'b0001);
    rd(MB + 32'h4, rv); chk("status_refill", rv, 32'h0002_0081);
    console_ready = 1'b1;
    wr(MB, 32'h58, 4'b0001);
    console_ready = 1'b0;
    rd(MB + 32'h4, rv); chk("status_push_pop_full", rv, 32'h0002_0081);
    console_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain2_data_%0d", i), console_data, 8'h51 + i);
      tick();
    end
    chk("drain2_done", console_valid, 0);

    // Empty FIFO, push with ready high: no bypass
    dmem_addr  = MB;
    dmem_wdata = 32'h60;
    dmem_wstrb = 4'b0001;
    dmem_write = 1'b1;
    #1;
    chk("nobypass_pre", console_valid, 0);
    tick();
    dmem_write = 1'b0;
    dmem_wstrb = 4'b0000;
    chk("nobypass_valid", console_valid, 1);
    chk("nobypass_data", console_data, 8'h60);
    tick();
    chk("nobypass_popped", console_valid, 0);
    console_ready = 1'b0;
    rd(MB, rv); chk("tx_reads_zero", rv, 32'h0);

    // TOHOST and other offsets
    wr(MB + 32'h10, 32'h1, 4'b1111);
    chk("tohost_valid", tohost_valid, 1);
    chk("tohost_data", tohost_data, 32'h1);
    rd(MB + 32'h10, rv);  chk("tohost_read", rv, 32'h1);
    rd(MB + 32'h20, rv);  chk("mmio_other_zero", rv, 32'h0);
    chk("mmio_other_no_fault", fault, 0);

    // Unmapped accesses
    rd(32'h2000_0000, rv); chk("unmapped_rdata", rv, 32'h0);
    chk("fault_set", fault, 1);
    chk("fault_addr_first", fault_addr, 32'h2000_0000);
    rd(32'h3000_0000, rv);
    chk("fault_addr_kept", fault_addr, 32'h2000_0000);

    // Asynchronous reset mid-cycle
    wr(MB, 32'h77, 4'b0001);
    chk("pre_reset_valid", console_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_console_valid", console_valid, 0);
    chk("arst_console_data", console_data, 0);
    chk("arst_tohost_valid", tohost_valid, 0);
    chk("arst_tohost_data", tohost_data, 0);
    chk("arst_fault", fault, 0);
    chk("arst_fault_addr", fault_addr, 0);
    tick();
    rst_n = 1'b1;
    rd(MB + 32'h8, rv);   chk("cycle_lo_first_cycle", rv, 32'h0);
    rd(32'h40, rv);       chk("ram_retained", rv, 32'h1234_5678);
    rd(MB + 32'h4, rv);   chk("status_after_reset", rv, 32'h0000_0002);

    // First address past the RAM is unmapped
    wr(32'h1000, 32'h5, 4'b1111);
    chk("ram_end_fault", fault, 1);
    chk("ram_end_fault_addr", fault_addr, 32'h0000_1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
